arb_req_queue: RTL and testbench
================================

# arb_req_queue

Requester-side front end for the priority arbiter: buffers requests from VECTOR_IN independent sources in per-port FIFOs and drives the arbiter's request_vector. It consumes the returned one-hot grant, pops the granted FIFO and presents the winning payload on a single registered valid/ready output. It sits between the source ports and the shared downstream resource, with the combinational arbiter closing the loop in the same cycle.

## Interface
- VECTOR_IN, 8, number of source ports (≥2)
- DATA_W, 64, payload width per request
- DEPTH, 4, entries per port FIFO (power of two, ≥2)
- PW, $clog2(VECTOR_IN), port-index width (derived, not overridable)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  VECTOR_IN  per-port request valid
- in_data  in  VECTOR_IN*DATA_W  per-port payload; port i at [i*DATA_W +: DATA_W]
- in_ready  out  VECTOR_IN  per-port accept; push on in_valid[i] & in_ready[i]
- request_vector  out  VECTOR_IN  to arbiter; bit i = FIFO i non-empty and output stage free
- grant  in  VECTOR_IN  from arbiter; combinational response to request_vector, same cycle
- out_valid  out  1  registered output payload valid
- out_data  out  DATA_W  granted payload
- out_port  out  PW  source index of out_data
- out_ready  in  1  downstream accept
- grant_err  out  1  one-cycle pulse: illegal grant observed

## Operation
- Per port: circular FIFO, DEPTH entries, rd/wr pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy count 0..DEPTH.
- in_ready[i] = (count[i] != DEPTH) & rst_n. A full FIFO refuses a push even in a cycle where it is popped.
- out_free = !out_valid | out_ready.
- request_vector[i] = (count[i] != 0) & out_free & rst_n. No bypass: a push into an empty FIFO raises request_vector[i] the next cycle.
- Legal grant: exactly one bit set, at index i, with request_vector[i]=1. On the edge, pop FIFO i, out_data <= head[i], out_port <= i, out_valid <= 1.
- Illegal grant: more than one bit set, or any set bit where request_vector=0. No pop, output stage unchanged, grant_err <= 1 for one cycle. Zero grant with nonzero request_vector is not an error; it is simply no transfer.
- Output hold: while out_valid & !out_ready, out_data and out_port stay stable and request_vector is all zero.
- out_valid clears on out_valid & out_ready when no new legal grant arrives the same cycle. A handoff plus a new grant in the same cycle loads the new payload back-to-back with no bubble.
- Simultaneous push and pop on one port: count unchanged, both pointers advance.
- Arbitration policy belongs to the arbiter. This block only enforces grant legality.

## Timing
- Reset (rst_n=0 at edge): all counts 0, all pointers 0, out_valid=0, out_data=0, out_port=0, grant_err=0. While rst_n=0, in_ready=0 and request_vector=0 combinationally.
- Reset mid-operation: every queued and in-flight entry is discarded, with no output handoff.
- Latency: push at edge N, request_vector at N+1, grant at N+1, out_valid at N+2.
- Throughput: one transfer per cycle while out_ready=1 and any FIFO is non-empty.
- grant_err asserts in the cycle after the offending grant and deasserts the following cycle unless repeated.
- No combinational path from in_valid/in_data to request_vector or outputs. request_vector depends combinationally on out_ready.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles while driving in_valid=8'hFF -> in_ready=0, request_vector=0, out_valid=0, no FIFO writes. Release -> in_ready=8'hFF.
- Single port latency: push data 64'hA5 on port 3 at cycle 0, out_ready=1 -> request_vector=8'h08 at cycle 1, out_valid=1, out_data=64'hA5, out_port=3 at cycle 2, then out_valid=0.
- Full/wrap: push 4 entries on port 0 with out_ready=0 -> in_ready[0]=0 after the 4th push. Pop all 4, then push 6 more with out_ready=1 -> data emerges in order across pointer wrap, with no loss or duplicate.
- Backpressure: out_valid=1 and out_ready=0 for 5 cycles -> out_data and out_port stable, request_vector=0. Raise out_ready with 2 ports pending -> back-to-back outputs, no bubble.
- Illegal grant: force grant=8'h06 with request_vector=8'h06 -> grant_err pulses once, FIFO counts unchanged, out_valid unchanged. Force grant=8'h10 with request_vector=8'h01 -> same response.
- Reset mid-stream: 3 ports holding 2 entries each, out_valid=1; assert rst_n=0 for 1 cycle -> all empty, out_valid=0, and no stale data after release.

Source files
------------

// File: rtl/arb_req_queue.sv
// Requester-side front end for the priority arbiter: per-port request FIFOs drive
// request_vector, the returned one-hot grant pops one FIFO into a registered output.
module arb_req_queue #(
  parameter  int VECTOR_IN = 8,
  parameter  int DATA_W    = 64,
  parameter  int DEPTH     = 4,
  localparam int PW        = $clog2(VECTOR_IN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [VECTOR_IN-1:0]        in_valid,
  input  logic [VECTOR_IN*DATA_W-1:0] in_data,
  output logic [VECTOR_IN-1:0]        in_ready,
  output logic [VECTOR_IN-1:0]        request_vector,
  input  logic [VECTOR_IN-1:0]        grant,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [PW-1:0]               out_port,
  input  logic                        out_ready,
  output logic                        grant_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PW-1:0]     port;
  } out_t;

  logic [VECTOR_IN-1:0][DATA_W-1:0] w_in_data;
  logic [VECTOR_IN-1:0][DATA_W-1:0] w_head;
  logic [VECTOR_IN-1:0]             w_full;
  logic [VECTOR_IN-1:0]             w_empty;
  logic [VECTOR_IN-1:0]             w_push;
  logic [VECTOR_IN-1:0]             w_pop;
  logic                             w_out_free;
  logic                             w_onehot;
  logic                             w_legal;
  logic                             w_illegal;
  out_t                             w_next;

  out_t r_out;
  logic r_out_valid;
  logic r_grant_err;

  assign w_in_data = in_data;

  // Per-port circular FIFO; pointers wrap naturally since DEPTH is a power of two.
  for (genvar g = 0; g < VECTOR_IN; g++) begin : g_port
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wr_ptr] <= w_in_data[g];
    end

    assign w_full[g]  = (r_count == CW'(DEPTH));
    assign w_empty[g] = (r_count == '0);
    assign w_head[g]  = r_mem[r_rd_ptr];
  end

  // Full refuses a push even when popped the same cycle, keeping in_ready free of grant.
  assign in_ready       = ~w_full & {VECTOR_IN{rst_n}};
  assign w_push         = in_valid & in_ready;
  assign w_out_free     = !r_out_valid || out_ready;
  assign request_vector = ~w_empty & {VECTOR_IN{w_out_free && rst_n}};

  always_comb begin
    w_onehot  = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    w_legal   = w_onehot && ((grant & ~request_vector) == '0);
    w_illegal = (grant != '0) && !w_legal;
  end

  assign w_pop = grant & {VECTOR_IN{w_legal}};

  always_comb begin
    w_next = '0;
    for (int i = 0; i < VECTOR_IN; i++) begin
      if (grant[i]) begin
        w_next.data = w_head[i];
        w_next.port = PW'(i);
      end
    end
  end

  // A legal grant only exists when the stage is free, so load covers handoff+reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_grant_err <= 1'b0;
    end else begin
      r_grant_err <= w_illegal;
      if (w_legal) begin
        r_out_valid <= 1'b1;
        r_out       <= w_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out.data;
  assign out_port  = r_out.port;
  assign grant_err = r_grant_err;

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: queue-based reference model plus scoreboard monitor,
// directed scenarios followed by randomized traffic, grants and resets.
module tb_arb_req_queue;
  localparam int N     = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_valid, in_ready, request_vector, grant;
  logic [N*DW-1:0] in_data;
  logic          out_valid, out_ready, grant_err;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_port;

  arb_req_queue #(.VECTOR_IN(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .request_vector(request_vector), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
    .out_ready(out_ready), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arbiter stand-in: rotating-start pick, or a forced (possibly illegal) grant.
  logic         force_en, arb_en;
  logic [N-1:0] force_grant;
  int           arb_start;

  always_comb begin
    grant = '0;
    if (force_en) grant = force_grant;
    else if (arb_en) begin
      for (int k = 0; k < N; k++)
        if (grant == '0 && request_vector[(arb_start + k) % N])
          grant[(arb_start + k) % N] = 1'b1;
    end
  end

  // Reference model: one queue per port, expected outputs pushed to sb.
  typedef struct { logic [DW-1:0] data; int port; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] q [N][$];
  bit            mvalid   = 0;
  bit            exp_err  = 0;
  bit            seen_rst = 0;

  always @(negedge clk) begin
    logic [N-1:0] mreq, mrdy, acc;
    bit           legal;
    int           g;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      mreq[i] = rst_n && (q[i].size() != 0) && (!mvalid || out_ready);
      mrdy[i] = rst_n && (q[i].size() != DEPTH);
    end
    if (seen_rst) begin
      chk("request_vector", request_vector, mreq);
      chk("in_ready", in_ready, mrdy);
      chk("out_valid", out_valid, mvalid);
      chk("grant_err", grant_err, exp_err);
    end
    if (!rst_n) begin
      for (int i = 0; i < N; i++) q[i].delete();
      sb.delete();
      mvalid   = 0;
      exp_err  = 0;
      seen_rst = 1;
    end else if (seen_rst) begin
      legal   = ($countones(grant) == 1) && ((grant & ~mreq) == '0);
      exp_err = (grant != '0) && !legal;
      acc     = in_valid & mrdy;
      if (legal) begin
        g = 0;
        for (int i = 0; i < N; i++) if (grant[i]) g = i;
        e.data = q[g].pop_front();
        e.port = g;
        sb.push_back(e);
        mvalid = 1;
      end else if (out_ready) begin
        mvalid = 0;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) q[i].push_back(in_data[i*DW +: DW]);
    end
  end

  // Monitor: every presented payload must match the oldest expected entry.
  always @(negedge clk) begin
    if (seen_rst && rst_n && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got port %0d data %0h, expected no output", out_port, out_data);
      end else begin
        chk("out_data", out_data, sb[0].data);
        chk("out_port", 64'(out_port), 64'(sb[0].port));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int p, input logic [DW-1:0] d);
    in_data[p*DW +: DW] = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '1; in_data = '0; out_ready = 1'b1;
    force_en = 1'b0; force_grant = '0; arb_en = 1'b1; arb_start = 0;

    // Reset / idle with all ports requesting
    repeat (3) begin
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_req", request_vector, 0);
      chk("rst_out_valid", out_valid, 0);
    end
    rst_n = 1'b1; in_valid = '0;
    #1;
    chk("rel_in_ready", in_ready, 8'hFF);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_grant_err", grant_err, 0);

    // Single-port latency
    set_data(3, 64'hA5); in_valid = 8'h08;
    step();
    in_valid = '0;
    chk("lat_req", request_vector, 8'h08);
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 64'hA5);
    chk("lat_port", out_port, 3);
    step();
    chk("lat_valid_clr", out_valid, 0);

    // Full, refused 5th push, drain, then refill across pointer wrap
    arb_en = 1'b0; out_ready = 1'b0; in_valid = 8'h01;
    for (int k = 0; k < 5; k++) begin
      set_data(0, 64'h100 + 64'(k));
      step();
    end
    in_valid = '0;
    chk("full_in_ready0", in_ready[0], 0);
    arb_en = 1'b1; out_ready = 1'b1;
    repeat (6) step();
    for (int k = 0; k < 6; k++) begin
      set_data(0, 64'h200 + 64'(k)); in_valid = 8'h01;
      step();
    end
    in_valid = '0;
    repeat (4) step();

    // Backpressure hold then back-to-back release
    out_ready = 1'b0;
    set_data(2, 64'hB2); set_data(5, 64'hB5); in_valid = 8'h24;
    step();
    in_valid = '0;
    step();
    repeat (5) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 64'hB2);
      chk("bp_port", out_port, 2);
      chk("bp_req", request_vector, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_req_release", request_vector, 8'h20);
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 64'hB5);
    chk("b2b_port", out_port, 5);
    step();
    chk("b2b_valid_clr", out_valid, 0);

    // Reset mid-stream
    arb_en = 1'b0; out_ready = 1'b0; in_valid = 8'h07;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 3; p++) set_data(p, 64'hC00 + 64'(p * 16 + k));
      step();
    end
    in_valid = '0; arb_en = 1'b1;
    step();
    chk("mid_valid", out_valid, 1);
    arb_en = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_req", request_vector, 0);
    chk("mid_rst_rdy", in_ready, 8'hFF);

    // Illegal grant: two bits set
    out_ready = 1'b1; set_data(1, 64'hD1); set_data(2, 64'hD2); in_valid = 8'h06;
    step();
    in_valid = '0;
    chk("ill1_req", request_vector, 8'h06);
    force_en = 1'b1; force_grant = 8'h06;
    step();
    force_en = 1'b0;
    #3;
    chk("ill1_err", grant_err, 1);
    chk("ill1_valid", out_valid, 0);
    step();
    #3;
    chk("ill1_err_clr", grant_err, 0);
    chk("ill1_req_kept", request_vector, 8'h06);
    arb_en = 1'b1;
    repeat (4) step();

    // Illegal grant: bit outside request_vector
    arb_en = 1'b0; set_data(0, 64'hE0); in_valid = 8'h01;
    step();
    in_valid = '0;
    chk("ill2_req", request_vector, 8'h01);
    force_en = 1'b1; force_grant = 8'h10;
    step();
    force_en = 1'b0;
    #3;
    chk("ill2_err", grant_err, 1);
    chk("ill2_valid", out_valid, 0);
    step();
    #3;
    chk("ill2_err_clr", grant_err, 0);
    chk("ill2_req_kept", request_vector, 8'h01);
    arb_en = 1'b1;
    repeat (3) step();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int p = 0; p < N; p++) set_data(p, {$urandom, $urandom});
      in_valid    = N'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      arb_en      = ($urandom_range(0, 9) < 8);
      arb_start   = $urandom_range(0, N - 1);
      force_en    = ($urandom_range(0, 29) == 0);
      force_grant = N'($urandom);
      step();
    end

    // Drain
    rst_n = 1'b1; in_valid = '0; out_ready = 1'b1; arb_en = 1'b1; force_en = 1'b0;
    repeat (60) step();
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_req", request_vector, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
